// File: rtl/cic_package.sv
// Shared CIC helpers: ceiling log2 plus the width and latency formulas for the interpolator.
package cic_package;

    // Smallest n with 2**n >= v (0 for v <= 1).
    function automatic int clog2(input int v);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    // Internal interpolator width: idw plus log2 of the DC gain (r*g)**m / r.
    function automatic int W_I(input int idw, input int r, input int g, input int m);
        int p;
        p = 1;
        for (int i = 0; i < m; i++) begin
            p = p * (r * g);
        end
        return idw + clog2(p / r);
    endfunction

    // Edges from an accepted sample to its first effect on data_out.
    function automatic int LAT_I(input int r, input int m);
        return (m - 1) * r + m + 1;
    endfunction

endpackage

// File: rtl/cic_i_upsampler.sv
// Rate control for the interpolator: phase counter, accept strobe, and zero-stuffing register.
module cic_upsampler
    import cic_package::*;
#(
    parameter int dw = 14,
    parameter int r  = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [dw-1:0] din,
    output logic          stb,
    output logic [dw-1:0] dout
);

    localparam int PW = (r > 1) ? clog2(r) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(r - 1);

    logic [PW-1:0] phase;
    logic          stb_d1;

    // Phase counter wraps every r clocks; the strobe is registered off the last phase.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= '0;
            stb   <= 1'b0;
        end else begin
            phase <= (phase == PHASE_LAST) ? '0 : phase + 1'b1;
            stb   <= (phase == PHASE_LAST);
        end
    end

    // One clock after the comb chain updates, pass its output once, then stuff zeros.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stb_d1 <= 1'b0;
            dout   <= '0;
        end else begin
            stb_d1 <= stb;
            dout   <= stb_d1 ? din : '0;
        end
    end

endmodule

// File: rtl/cic_i.sv
// CIC interpolator: m combs at the input rate, zero-stuff by r, m integrators at the clock rate.
module cic_i
    import cic_package::*;
#(
    parameter int idw = 8,
    parameter int odw = 8,
    parameter int r   = 4,
    parameter int m   = 4,
    parameter int g   = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [idw-1:0] data_in,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [odw-1:0] data_out,
    output logic           out_dv,
    output logic           underrun
);

    localparam int W     = W_I(idw, r, g, m);
    localparam int LAT   = LAT_I(r, m);
    // First strobe lands r+1 edges after release; output becomes meaningful LAT edges later.
    localparam int DV_AT = r + LAT;
    localparam int CW    = clog2(DV_AT + 2);

    logic         stb;
    logic [W-1:0] sample;
    logic [W-1:0] us;
    logic [W-1:0] comb_in  [m];
    logic [W-1:0] comb_out [m];
    logic [W-1:0] int_in   [m];
    logic [W-1:0] int_out  [m];
    logic [CW-1:0] dv_cnt;

    // A missed accept slot feeds a zero sample rather than stalling the chain.
    assign sample   = in_valid ? W'(signed'(data_in)) : '0;
    assign in_ready = stb;

    cic_upsampler #(
        .dw (W),
        .r  (r)
    ) u_upsampler (
        .clk   (clk),
        .reset (reset),
        .din   (comb_out[m-1]),
        .stb   (stb),
        .dout  (us)
    );

    for (genvar j = 0; j < m; j++) begin : g_comb
        logic [W-1:0] q;
        logic [W-1:0] dly [g];

        if (j == 0) begin : g_first
            assign comb_in[j] = sample;
        end else begin : g_next
            assign comb_in[j] = comb_out[j-1];
        end
        assign comb_out[j] = q;

        // Comb stage: difference against the input g strobes ago, advancing only on stb.
        // NOTE: the g-deep delay line is a few registers, so it is cleared on reset like any other state.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                q <= '0;
                for (int i = 0; i < g; i++) begin
                    dly[i] <= '0;
                end
            end else if (stb) begin
                q      <= comb_in[j] - dly[g-1];
                dly[0] <= comb_in[j];
                for (int i = 1; i < g; i++) begin
                    dly[i] <= dly[i-1];
                end
            end
        end
    end

    for (genvar k = 0; k < m; k++) begin : g_int
        logic [W-1:0] acc;

        if (k == 0) begin : g_first
            assign int_in[k] = us;
        end else begin : g_next
            assign int_in[k] = int_out[k-1];
        end
        assign int_out[k] = acc;

        // Integrator stage: free-running accumulate, wrapping modulo 2**W.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                acc <= '0;
            end else begin
                acc <= acc + int_in[k];
            end
        end
    end

    // Output is the truncated top of the last integrator.
    assign data_out = int_out[m-1][W-1 -: odw];

    // Flag an accept slot that passed without a valid sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun <= 1'b0;
        end else begin
            underrun <= stb & ~in_valid;
        end
    end

    // Count from release until the first sample reaches the output, then hold out_dv.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dv_cnt <= '0;
            out_dv <= 1'b0;
        end else if (!out_dv) begin
            dv_cnt <= dv_cnt + 1'b1;
            out_dv <= (dv_cnt == CW'(DV_AT));
        end
    end

endmodule

// File: tb/tb_cic_i.sv
// Scoreboard bench for cic_i at default parameters (W = 14, latency 17).
module tb_cic_i;

    typedef enum int {K_DATA, K_READY, K_DV, K_UNDER} kind_t;
    typedef struct {
        int    cyc;
        kind_t kind;
        int    val;
        string name;
    } exp_t;

    // Output after edge OFF+n' is sum_s x_s * h[n' - 4s]; first sample accepted at edge 5.
    localparam int OFF = 22;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] data_out;
    logic       out_dv;
    logic       underrun;

    int   cyc;
    int   errors = 0;
    int   checks = 0;
    exp_t sb [$];

    // Impulse response of (1+z^-1+z^-2+z^-3)^4, and DC-10 output with one sample missing.
    int h_tab   [13] = '{1, 4, 10, 20, 31, 40, 44, 40, 31, 20, 10, 4, 1};
    int dip_tab [13] = '{9, 9, 8, 6, 5, 3, 3, 3, 5, 6, 8, 9, 9};

    cic_i dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data_out (data_out),
        .out_dv   (out_dv),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input int c, input kind_t k, input int v, input string nm);
        exp_t e;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic push_window(input int n0, input int n1, input int v, input string nm);
        for (int n = n0; n <= n1; n++) push(n + OFF, K_DATA, v, nm);
    endtask

    // Strobe, out_dv and pre-valid output timing, identical after every reset release.
    task automatic push_startup();
        for (int c = 1; c <= 9; c++) push(c, K_READY, (c == 4 || c == 8) ? 1 : 0, "in_ready");
        push(21, K_DV, 0, "out_dv_pre");
        push(22, K_DV, 1, "out_dv_rise");
        push(10, K_DATA, 0, "data_pre_dv");
        push(21, K_DATA, 0, "data_pre_dv");
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Present sample s for its accept edge 4s+5.
    task automatic drive(input int s, input int v, input bit vld);
        wait_until(4 * s + 4);
        data_in  = 8'(v);
        in_valid = vld;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations never reached", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, int'(in_ready), 0);
        check({tag, "_out_dv"}, int'(out_dv), 0);
        check({tag, "_data_out"}, int'($signed(data_out)), 0);
        check({tag, "_underrun"}, int'(underrun), 0);
    endtask

    // Monitor: compare every expectation due at this cycle, flag any that were skipped.
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < sb.size(); ) begin
                if (sb[i].cyc == cyc) begin
                    int act;
                    case (sb[i].kind)
                        K_DATA:  act = int'($signed(data_out));
                        K_READY: act = int'(in_ready);
                        K_DV:    act = int'(out_dv);
                        default: act = int'(underrun);
                    endcase
                    check($sformatf("%s@%0d", sb[i].name, cyc), act, sb[i].val);
                    sb.delete(i);
                end else if (sb[i].cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s@%0d: not observed by cycle %0d", sb[i].name, sb[i].cyc, cyc);
                    sb.delete(i);
                end else begin
                    i++;
                end
            end
        end
    end

    initial begin
        int vals [46];
        bit vld  [46];

        for (int s = 0; s < 46; s++) begin
            vld[s] = 1'b1;
            if (s <= 11)      vals[s] = 10;
            else if (s <= 17) vals[s] = -10;
            else if (s <= 23) vals[s] = -128;
            else if (s == 29) vals[s] = 64;
            else if (s <= 35) vals[s] = 0;
            else              vals[s] = 10;
        end
        vals[6] = 99;
        vld[6]  = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_state("por");
        reset = 1'b0;

        // Epoch 1: DC, underrun dip, negative DC, full-scale DC, impulse, DC before reset.
        push_startup();
        push_window(9, 23, 10, "dc10");
        for (int j = 0; j < 13; j++) push(24 + j + OFF, K_DATA, dip_tab[j], "dip");
        push_window(37, 47, 10, "dc10_after_dip");
        push_window(57, 71, -10, "dc_m10");
        push_window(81, 95, -128, "dc_m128");
        push_window(105, 115, 0, "zero");
        for (int j = 0; j < 13; j++) push(116 + j + OFF, K_DATA, h_tab[j], "impulse");
        push_window(129, 143, 0, "impulse_tail");
        push(190, K_DATA, 10, "dc10_pre_reset");
        push(25, K_UNDER, 0, "underrun_idle");
        push(28, K_UNDER, 0, "underrun_before");
        push(29, K_UNDER, 1, "underrun_pulse");
        push(30, K_UNDER, 0, "underrun_after");
        push(28, K_READY, 1, "in_ready_underrun_slot");
        push(29, K_DV, 1, "out_dv_underrun");
        push(30, K_DV, 1, "out_dv_underrun");
        push(150, K_DV, 1, "out_dv_hold");

        for (int s = 0; s < 46; s++) drive(s, vals[s], vld[s]);
        wait_until(190);
        drain();

        // Mid-stream reset: outputs clear without waiting for a clock edge.
        #2 reset = 1'b1;
        #1 check_reset_state("mid");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Epoch 2: sequencing restarts exactly as from power-up.
        push_startup();
        push_window(9, 27, 10, "dc10_restart");
        for (int s = 0; s < 8; s++) drive(s, 10, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cic_i.md
Name: cic_i

Overview:
- CIC interpolator: the transmit-side counterpart of the team's CIC decimator. It accepts one low-rate sample every r clocks and produces one high-rate sample per clock.
- Datapath order: m comb stages at the input rate, then a zero-stuffing upsampler by r, then m integrators at the clock rate.
- Output is the top odw bits of the full-precision integrator chain.
- Sits between a baseband sample source (valid/ready) and a DAC-rate consumer.

Parameters:
- idw, 8, input data width (signed)
- odw, 8, output data width (signed), odw <= W
- r, 4, interpolation ratio, >= 2
- m, 4, CIC order (number of comb stages and number of integrator stages)
- g, 1, differential delay in combs, 1 or 2

Ports:
- clk  in  1  high-rate clock
- reset  in  1  asynchronous, active-high reset
- data_in  in  idw  signed input sample
- in_valid  in  1  data_in valid
- in_ready  out  1  accept slot; high one cycle in every r
- data_out  out  odw  signed interpolated sample, one per clock
- out_dv  out  1  data_out valid
- underrun  out  1  one-cycle pulse: accept slot passed with in_valid low

Behaviour:
- Internal width: W = idw + clog2((r*g)**m / r). Defaults give W = 14.
- All internal arithmetic is two's complement at width W, sign-extended from input, wrap-around modulo 2^W. No saturation.
- Reset (asynchronous, while reset=1):
  - phase = 0; all comb, delay, upsampler and integrator registers = 0.
  - in_ready = 0, out_dv = 0, underrun = 0, data_out = 0.
- Phase counter:
  - Counts 0..r-1 and wraps, advancing every clock after reset release.
  - in_ready = (phase == r-1), registered. First in_ready is r clocks after reset deassertion, then every r clocks.
- Strobe stb = in_ready.
  - At an stb edge, stage 0 takes data_in if in_valid = 1, otherwise 0. In the zero case underrun pulses for 1 cycle.
  - in_valid outside stb is ignored; no sample is consumed.
- Comb stage j:
  - Registered and enabled only by stb.
  - On stb: out_j <= in_j - in_j delayed by g strobes. The g-deep delay line also shifts only on stb.
  - Stage 0 input is the accepted sample; stage j input is out_{j-1}.
- Upsampler register: us <= stb_d1 ? out_{m-1} : 0 every clock, where stb_d1 is stb delayed one clock. Exactly one non-zero-capable sample per r clocks.
- Integrator k: acc_k <= acc_k + in_k every clock. in_0 = us; in_k = acc_{k-1}.
- data_out = acc_{m-1}[W-1 : W-odw] (truncation, no rounding).
- Latency: a sample accepted at edge t first affects data_out after edge t + (m-1)*r + m + 1. Defaults: t + 17.
- out_dv:
  - Rises at edge t0 + (m-1)*r + m + 1, where t0 is the first stb edge after reset.
  - Stays high every cycle until reset, including through underruns.
- Gain: DC gain is (r*g)**m / r at full width, i.e. exactly 2^(W-idw) when r*g is a power of two. With idw = odw, the steady-state data_out equals the DC input.
- Reset mid-operation: all state clears immediately. Sequencing restarts exactly as from power-up, and no partial sample survives.

Decomposition:
- Add to cic_package:
  - function W_I(idw, r, g, m), returning the internal width W.
  - function LAT_I(r, m), returning the latency (m-1)*r + m + 1.
- Reuse cic_package clog2 helpers; no new typedefs.
- One sub-module: cic_upsampler (parameters dw, r). It owns the phase counter, in_ready/stb generation, stb_d1, and the zero-stuffing register.
- Comb and integrator stages are generate loops inside cic_i with active-high async reset.

Test Plan:
- Reset release, in_valid held 1 -> in_ready first high r = 4 clocks after release, then every 4 clocks. out_dv rises 17 clocks after the first stb. data_out = 0 before out_dv.
- DC input 10 on every accept -> after (m-1)*r + m + 1 + m*r clocks, data_out = 10 on every clock. Full-width acc_{m-1} = 640.
- DC input -10 -> steady data_out = -10 (acc = -640). DC -128 -> steady -128, no wrap visible at output.
- Single impulse 64 then zeros -> full-width output sequence sums to 64*256 over its response. Response ends after m*r + r clocks, then data_out returns to 0 and stays there.
- in_valid deasserted for one accept slot during DC 10 -> underrun pulses for exactly 1 cycle at that slot. The output dips, then returns to 10. out_dv stays 1.
- Assert reset for 1 cycle mid-stream -> outputs go to 0 asynchronously and out_dv drops. After release, in_ready/out_dv timing repeats the first scenario exactly.
